// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch/issue sequencer: PC, IR, imem req/ack port, valid/ready issue.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instr,
  output logic [3:0]      opcode,
  output logic [PC_W-1:0] pc_out,
  output logic            issue_valid,
  input  logic            issue_ready,
  input  logic            branch,
  input  logic            bra,
  input  logic            zero,
`ifdef IFU_PERF_CNT_EN
  output logic [15:0]     instr_count,
  output logic [15:0]     taken_count,
`endif
  output logic            halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0]  OP_HALT  = 4'hE;
  // Reset IR decodes as HALT, which the control unit treats as a no-op.
  localparam logic [15:0] IR_RESET = 16'hE000;

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [15:0]     ir, ir_next;
  logic [PC_W-1:0] pc_out_next;
  logic [PC_W-1:0] branch_offset;
  logic            handshake;
  logic            taken;

  assign imem_addr = pc;
  assign instr     = ir;
  assign opcode    = ir[15:12];

  // Signed size cast sign-extends (or truncates) the 8-bit offset to PC_W.
  assign branch_offset = PC_W'($signed(ir[7:0]));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ir_next     = ir;
    pc_out_next = pc_out;
    handshake   = 1'b0;
    taken       = 1'b0;
    unique case (state)
      FETCH: begin
        if (imem_req && imem_ack) begin
          ir_next     = imem_rdata;
          pc_out_next = pc;
          state_next  = DECODE;
        end
      end
      DECODE: begin
        if (ir[15:12] == OP_HALT) begin
          state_next = HALTED;
        end else if (issue_valid && issue_ready) begin
          handshake  = 1'b1;
          taken      = branch && (bra || zero);
          pc_next    = taken ? (pc + PC_W'(1) + branch_offset) : (pc + PC_W'(1));
          state_next = FETCH;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= IR_RESET;
      pc_out      <= RESET_PC;
      imem_req    <= 1'b0;
      issue_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      ir          <= ir_next;
      pc_out      <= pc_out_next;
      // Outputs are registered from the next state so they line up with it.
      imem_req    <= (state_next == FETCH);
      issue_valid <= (state_next == DECODE) && (ir_next[15:12] != OP_HALT);
      halted      <= (state_next == HALTED);
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= '0;
      taken_count <= '0;
    end else begin
      if (handshake)          instr_count <= instr_count + 16'd1;
      if (handshake && taken) taken_count <= taken_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; covers IFU_PERF_CNT_EN when defined.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  pc_out;
  logic        issue_valid;
  logic        issue_ready;
  logic        branch;
  logic        bra;
  logic        zero;
  logic        halted;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] instr_count;
  logic [15:0] taken_count;
`endif

  logic [15:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  assign imem_rdata = mem[imem_addr];

  instr_fetch_unit #(.PC_W(8), .RESET_PC(8'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .pc_out      (pc_out),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .branch      (branch),
    .bra         (bra),
    .zero        (zero),
`ifdef IFU_PERF_CNT_EN
    .instr_count (instr_count),
    .taken_count (taken_count),
`endif
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!issue_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, {31'd0, issue_valid}, 32'd1);
  endtask

  // Perform one issue handshake with the given branch inputs; afterwards the next fetch is visible.
  task automatic issue_one(input logic br, input logic b, input logic z);
    wait_valid("wait_valid");
    branch = br;
    bra    = b;
    zero   = z;
    step();
    branch = 1'b0;
    bra    = 1'b0;
    zero   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b1;
    issue_ready = 1'b1;
    branch = 1'b0;
    bra = 1'b0;
    zero = 1'b0;
    clear_mem();

    // Reset values and zero-wait sequence 0x1000, 0x3000, HALT.
    mem[0] = 16'h1000;
    mem[1] = 16'h3000;
    mem[2] = 16'hE000;
    do_reset();
    check("rst_req",    {31'd0, imem_req},    32'd0);
    check("rst_valid",  {31'd0, issue_valid}, 32'd0);
    check("rst_halted", {31'd0, halted},      32'd0);
    check("rst_pc_out", {24'd0, pc_out},      32'd0);
    check("rst_opcode", {28'd0, opcode},      32'hE);
    check("rst_instr",  {16'd0, instr},       32'hE000);
    check("rst_addr",   {24'd0, imem_addr},   32'd0);
    step();
    check("f0_req",  {31'd0, imem_req},  32'd1);
    check("f0_addr", {24'd0, imem_addr}, 32'd0);
    step();
    check("d0_opcode", {28'd0, opcode},      32'h1);
    check("d0_valid",  {31'd0, issue_valid}, 32'd1);
    check("d0_req",    {31'd0, imem_req},    32'd0);
    step();
    check("f1_addr",  {24'd0, imem_addr},   32'd1);
    check("f1_req",   {31'd0, imem_req},    32'd1);
    check("f1_valid", {31'd0, issue_valid}, 32'd0);
    step();
    check("d1_opcode", {28'd0, opcode}, 32'h3);
    check("d1_pc_out", {24'd0, pc_out}, 32'd1);
    step();
    check("f2_addr", {24'd0, imem_addr}, 32'd2);
    step();
    check("h_valid",  {31'd0, issue_valid}, 32'd0);
    check("h_halted", {31'd0, halted},      32'd0);
    check("h_req",    {31'd0, imem_req},    32'd0);
    step();
    check("h_halted1", {31'd0, halted},   32'd1);
    check("h_req1",    {31'd0, imem_req}, 32'd0);
    step();
    check("h_req2",    {31'd0, imem_req}, 32'd0);

    // boz at PC 4, taken.
    clear_mem();
    mem[4] = 16'h6005;
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(1'b0, 1'b0, 1'b0);
    check("boz_pc", {24'd0, imem_addr}, 32'd4);
    wait_valid("boz_valid");
    check("boz_opcode", {28'd0, opcode}, 32'h6);
    issue_one(1'b1, 1'b0, 1'b1);
    check("boz_taken_addr", {24'd0, imem_addr}, 32'd10);
    check("boz_taken_req",  {31'd0, imem_req},  32'd1);

    // boz at PC 4, not taken.
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(1'b0, 1'b0, 1'b0);
    issue_one(1'b1, 1'b0, 1'b0);
    check("boz_nt_addr", {24'd0, imem_addr}, 32'd5);

    // bra -2 at PC 3 (zero=0 so only bra makes it taken).
    clear_mem();
    mem[3] = 16'h80FE;
    do_reset();
    for (int i = 0; i < 3; i++) issue_one(1'b0, 1'b0, 1'b0);
    issue_one(1'b1, 1'b1, 1'b0);
    check("bra_back_addr", {24'd0, imem_addr}, 32'd2);

    // Backward wrap 0 -> 255, then forward wrap 255 -> 5.
    clear_mem();
    mem[0]   = 16'h80FE;
    mem[255] = 16'h8005;
    do_reset();
    issue_one(1'b1, 1'b1, 1'b0);
    check("wrap_back_addr", {24'd0, imem_addr}, 32'd255);
    issue_one(1'b1, 1'b1, 1'b0);
    check("wrap_fwd_addr", {24'd0, imem_addr}, 32'd5);

    // Delayed ack (3 cycles) and issue_ready low for 2 cycles.
    clear_mem();
    mem[0] = 16'h3000;
    imem_ack = 1'b0;
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      check("wait_req",  {31'd0, imem_req},  32'd1);
      check("wait_addr", {24'd0, imem_addr}, 32'd0);
      step();
    end
    check("wait_req3", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    issue_ready = 1'b0;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stall_instr", {16'd0, instr},       32'h3000);
      check("stall_valid", {31'd0, issue_valid}, 32'd1);
      check("stall_req",   {31'd0, imem_req},    32'd0);
      step();
    end
    check("stall_opcode", {28'd0, opcode}, 32'h3);
    issue_ready = 1'b1;
    step();
    check("stall_adv_addr",  {24'd0, imem_addr},   32'd1);
    check("stall_adv_valid", {31'd0, issue_valid}, 32'd0);
    check("stall_pc_out",    {24'd0, pc_out},      32'd0);
    imem_ack = 1'b1;

    // Reset while issue_valid=1.
    clear_mem();
    do_reset();
    issue_ready = 1'b0;
    step();
    step();
    check("pre_rst_valid", {31'd0, issue_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_iss_opcode", {28'd0, opcode},      32'hE);
    check("rst_iss_valid",  {31'd0, issue_valid}, 32'd0);
    check("rst_iss_addr",   {24'd0, imem_addr},   32'd0);

    // Reset while awaiting ack, with a late ack landing on the reset edge and after it.
    imem_ack = 1'b0;
    step();
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    imem_ack = 1'b1;
    step();
    rst = 1'b0;
    check("rst_ack_instr", {16'd0, instr},       32'hE000);
    check("rst_ack_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_ack_req",   {31'd0, imem_req},    32'd0);
    step();
    check("late_ack_opcode", {28'd0, opcode},      32'hE);
    check("late_ack_valid",  {31'd0, issue_valid}, 32'd0);
    issue_ready = 1'b1;
    imem_ack = 1'b1;

`ifdef IFU_PERF_CNT_EN
    // 5 instructions: 2 taken, 1 not-taken branch, then HALT.
    clear_mem();
    mem[0] = 16'h1000;
    mem[1] = 16'h6002;
    mem[4] = 16'h6002;
    mem[5] = 16'h8001;
    mem[7] = 16'h3000;
    mem[8] = 16'hE000;
    do_reset();
    check("cnt_rst_instr", {16'd0, instr_count}, 32'd0);
    check("cnt_rst_taken", {16'd0, taken_count}, 32'd0);
    issue_one(1'b0, 1'b0, 1'b0);
    issue_one(1'b1, 1'b0, 1'b1);
    check("cnt_boz_addr", {24'd0, imem_addr}, 32'd4);
    issue_one(1'b1, 1'b0, 1'b0);
    issue_one(1'b1, 1'b1, 1'b0);
    check("cnt_bra_addr", {24'd0, imem_addr}, 32'd7);
    issue_one(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !halted; i++) step();
    check("cnt_halted", {31'd0, halted}, 32'd1);
    check("cnt_instr",  {16'd0, instr_count}, 32'd5);
    check("cnt_taken",  {16'd0, taken_count}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
